// File: rtl/ball_pkg.sv
// ball_pkg
// Shared definitions for the ball kinematics path (ball_motion, velocity_decay,
// hit_controller): ball state encoding, velocity type, pixel-width constants and
// the default number of fractional position bits.
package ball_pkg;

    // Width of one integer pixel coordinate / one velocity component.
    localparam int PIX_W = 11;

    // Default fractional bits of the position accumulators.
    localparam int DEFAULT_FRAC_BITS = 6;

    // One velocity component, in 1/2^FRAC_BITS pixel per frame.
    typedef logic signed [PIX_W-1:0] vel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_SUNK   = 2'd2
    } ball_state_t;

endpackage

// File: rtl/velocity_decay.sv
// velocity_decay
// Combinational friction step for one velocity component: moves the value
// toward zero by FRICTION_STEP. A value whose magnitude is not larger than the
// step becomes exactly zero, so the sign never flips.
// Ports:
//   vel_in  - current component (signed)
//   vel_out - component after one friction step (signed)
module velocity_decay
    import ball_pkg::*;
#(
    parameter int FRICTION_STEP = 1
) (
    input  logic signed [PIX_W-1:0] vel_in,
    output logic signed [PIX_W-1:0] vel_out
);

    // One extra bit so negating the step and comparing against -1024 is safe.
    localparam logic signed [PIX_W:0] STEP = (PIX_W + 1)'(FRICTION_STEP);

    logic signed [PIX_W:0] wide;
    logic signed [PIX_W:0] res;

    always_comb begin
        wide = {vel_in[PIX_W-1], vel_in};
        res  = '0;
        if (wide > STEP) begin
            res = wide - STEP;
        end else if (wide < -STEP) begin
            res = wide + STEP;
        end
        vel_out = PIX_W'(res);
    end

endmodule

// File: rtl/ball_motion.sv
// ball_motion
// Kinematics engine for one ball: holds a fixed-point position and a velocity,
// launches on a cue shot, integrates once per frame, applies periodic friction,
// accepts corrected velocities / hole events from hit_controller.
//
// Optional feature: define BALL_SPEED_CLAMP_EN to saturate shot and collision
// velocities per component to +/-MAX_SPEED before they are loaded. Without it
// the full 11-bit range is loaded unchanged.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   startOfFrame          - one-cycle pulse per video frame
//   shotValid/shotVelX/Y  - cue shot request and velocity; shotReady high in IDLE
//   collisionOccurred     - corrected velocity velXIn/velYIn valid (level)
//   holeHit, respawn      - ball sunk / return sunk ball to start position
//   topLeftPosX/Y         - integer pixel position (floor of accumulator)
//   velX, velY            - current velocity
//   moving, sunk          - state indicators
module ball_motion
    import ball_pkg::*;
#(
    parameter int INIT_X          = 280,
    parameter int INIT_Y          = 220,
    parameter int FRAC_BITS       = DEFAULT_FRAC_BITS,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRICTION_STEP   = 1,
    parameter int MAX_SPEED       = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    shotValid,
    input  logic signed [PIX_W-1:0] shotVelX,
    input  logic signed [PIX_W-1:0] shotVelY,
    output logic                    shotReady,
    input  logic                    collisionOccurred,
    input  logic signed [PIX_W-1:0] velXIn,
    input  logic signed [PIX_W-1:0] velYIn,
    input  logic                    holeHit,
    input  logic                    respawn,
    output logic signed [PIX_W-1:0] topLeftPosX,
    output logic signed [PIX_W-1:0] topLeftPosY,
    output logic signed [PIX_W-1:0] velX,
    output logic signed [PIX_W-1:0] velY,
    output logic                    moving,
    output logic                    sunk
);

    localparam int POS_W = PIX_W + FRAC_BITS;
    typedef logic signed [POS_W-1:0] pos_t;

    localparam pos_t INIT_X_FP = pos_t'(INIT_X) << FRAC_BITS;
    localparam pos_t INIT_Y_FP = pos_t'(INIT_Y) << FRAC_BITS;

    localparam logic [15:0] FRIC_LAST = 16'(FRICTION_PERIOD - 1);
    localparam vel_t        SPEED_LIM = vel_t'(MAX_SPEED);

    function automatic vel_t clamp_vel(input vel_t v);
        if (v > SPEED_LIM) begin
            return SPEED_LIM;
        end else if (v < -SPEED_LIM) begin
            return -SPEED_LIM;
        end
        return v;
    endfunction

    // Shot and collision velocities both pass through here before loading.
    function automatic vel_t load_vel(input vel_t v);
`ifdef BALL_SPEED_CLAMP_EN
        return clamp_vel(v);
`else
        return v;
`endif
    endfunction

    ball_state_t state_q, state_d;
    vel_t        vel_x_q, vel_x_d;
    vel_t        vel_y_q, vel_y_d;
    pos_t        pos_x_q, pos_x_d;
    pos_t        pos_y_q, pos_y_d;
    logic        lock_q, lock_d;
    logic [15:0] fric_cnt_q, fric_cnt_d;

    vel_t        decay_x, decay_y;
    logic        fric_wrap;

    velocity_decay #(.FRICTION_STEP(FRICTION_STEP)) u_decay_x (
        .vel_in (vel_x_q),
        .vel_out(decay_x)
    );

    velocity_decay #(.FRICTION_STEP(FRICTION_STEP)) u_decay_y (
        .vel_in (vel_y_q),
        .vel_out(decay_y)
    );

    assign fric_wrap = startOfFrame && (fric_cnt_q == FRIC_LAST);

    always_comb begin
        state_d    = state_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        lock_d     = lock_q;
        fric_cnt_d = fric_cnt_q;

        // The collision lock lasts until the next frame boundary.
        if (startOfFrame) begin
            lock_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (shotValid) begin
                    state_d    = ST_MOVING;
                    vel_x_d    = load_vel(shotVelX);
                    vel_y_d    = load_vel(shotVelY);
                    fric_cnt_d = '0;
                    lock_d     = 1'b0;
                end
            end

            ST_MOVING: begin
                if (holeHit) begin
                    state_d    = ST_SUNK;
                    vel_x_d    = '0;
                    vel_y_d    = '0;
                    lock_d     = 1'b0;
                    fric_cnt_d = '0;
                end else begin
                    // Integration uses the velocity registered before this cycle.
                    if (startOfFrame) begin
                        pos_x_d    = pos_x_q + pos_t'(vel_x_q);
                        pos_y_d    = pos_y_q + pos_t'(vel_y_q);
                        fric_cnt_d = fric_wrap ? '0 : fric_cnt_q + 16'd1;
                    end
                    // A collision load wins over friction and is taken unmodified;
                    // the lock stays set even if a frame boundary coincides.
                    if (collisionOccurred && !lock_q) begin
                        vel_x_d = load_vel(velXIn);
                        vel_y_d = load_vel(velYIn);
                        lock_d  = 1'b1;
                    end else if (fric_wrap) begin
                        vel_x_d = decay_x;
                        vel_y_d = decay_y;
                        if (decay_x == '0 && decay_y == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_SUNK: begin
                if (respawn) begin
                    state_d = ST_IDLE;
                    pos_x_d = INIT_X_FP;
                    pos_y_d = INIT_Y_FP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            vel_x_q    <= '0;
            vel_y_q    <= '0;
            pos_x_q    <= INIT_X_FP;
            pos_y_q    <= INIT_Y_FP;
            lock_q     <= 1'b0;
            fric_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            lock_q     <= lock_d;
            fric_cnt_q <= fric_cnt_d;
        end
    end

    // Arithmetic shift floors toward negative infinity.
    assign topLeftPosX = PIX_W'(pos_x_q >>> FRAC_BITS);
    assign topLeftPosY = PIX_W'(pos_y_q >>> FRAC_BITS);
    assign velX        = vel_x_q;
    assign velY        = vel_y_q;
    assign shotReady   = (state_q == ST_IDLE);
    assign moving      = (state_q == ST_MOVING);
    assign sunk        = (state_q == ST_SUNK);

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion
// Scoreboard bench for ball_motion with default parameters. Stimulus pushes the
// reference model's expected outputs; a monitor pops and compares every cycle.
module tb_ball_motion;

    localparam int FB     = 6;
    localparam int PERIOD = 4;
    localparam int STEP   = 1;
    localparam int MAXS   = 512;
    localparam int IX     = 280;
    localparam int IY     = 220;
    localparam int POSW   = 17;

    logic clk = 1'b0;
    logic reset, startOfFrame, shotValid, collisionOccurred, holeHit, respawn;
    logic signed [10:0] shotVelX, shotVelY, velXIn, velYIn;
    logic shotReady, moving, sunk;
    logic signed [10:0] topLeftPosX, topLeftPosY, velX, velY;

    always #5 clk = ~clk;

    ball_motion dut (
        .clk              (clk),
        .reset            (reset),
        .startOfFrame     (startOfFrame),
        .shotValid        (shotValid),
        .shotVelX         (shotVelX),
        .shotVelY         (shotVelY),
        .shotReady        (shotReady),
        .collisionOccurred(collisionOccurred),
        .velXIn           (velXIn),
        .velYIn           (velYIn),
        .holeHit          (holeHit),
        .respawn          (respawn),
        .topLeftPosX      (topLeftPosX),
        .topLeftPosY      (topLeftPosY),
        .velX             (velX),
        .velY             (velY),
        .moving           (moving),
        .sunk             (sunk)
    );

    typedef struct {
        int px, py, vx, vy;
        bit rdy, mov, snk;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 moving, 2 sunk; positions in 1/64 pixel.
    int m_st, m_px, m_py, m_vx, m_vy, m_frames;
    bit m_lock;

    function automatic int lim(input int v);
`ifdef BALL_SPEED_CLAMP_EN
        if (v > MAXS) return MAXS;
        if (v < -MAXS) return -MAXS;
`endif
        return v;
    endfunction

    function automatic int toward0(input int v);
        int mag;
        mag = (v < 0) ? -v : v;
        if (mag <= STEP) return 0;
        return (v < 0) ? v + STEP : v - STEP;
    endfunction

    function automatic int wrapacc(input int v);
        logic signed [POSW-1:0] t;
        t = v[POSW-1:0];
        return int'(t);
    endfunction

    function automatic int floor_pix(input int v);
        int q;
        q = v / 64;
        if (v < 0 && q * 64 != v) q = q - 1;
        return q;
    endfunction

    task automatic model_step(input bit rs, input bit sof, input bit sv, input int sx, input int sy,
                              input bit co, input int ix, input int iy, input bit hh, input bit rp);
        int ovx, ovy;
        bit fric;
        exp_t e;
        fric = 1'b0;
        if (rs) begin
            m_st = 0; m_px = IX * 64; m_py = IY * 64; m_vx = 0; m_vy = 0;
            m_lock = 0; m_frames = 0;
        end else if (m_st == 0) begin
            if (sv) begin
                m_st = 1; m_vx = lim(sx); m_vy = lim(sy); m_frames = 0; m_lock = 0;
            end
        end else if (m_st == 1) begin
            if (hh) begin
                m_st = 2; m_vx = 0; m_vy = 0; m_lock = 0;
            end else begin
                ovx = m_vx;
                ovy = m_vy;
                if (sof) begin
                    m_px = wrapacc(m_px + ovx);
                    m_py = wrapacc(m_py + ovy);
                    m_frames++;
                    fric = (m_frames % PERIOD) == 0;
                end
                if (co && !m_lock) begin
                    m_vx = lim(ix); m_vy = lim(iy); m_lock = 1;
                end else begin
                    if (sof) m_lock = 0;
                    if (fric) begin
                        m_vx = toward0(ovx);
                        m_vy = toward0(ovy);
                        if (m_vx == 0 && m_vy == 0) m_st = 0;
                    end
                end
            end
        end else begin
            if (rp) begin
                m_st = 0; m_px = IX * 64; m_py = IY * 64;
            end
        end
        e.px  = floor_pix(m_px);
        e.py  = floor_pix(m_py);
        e.vx  = m_vx;
        e.vy  = m_vy;
        e.rdy = (m_st == 0);
        e.mov = (m_st == 1);
        e.snk = (m_st == 2);
        sbq.push_back(e);
    endtask

    task automatic drive(input bit rs, input bit sof, input bit sv, input int sx, input int sy,
                         input bit co, input int ix, input int iy, input bit hh, input bit rp);
        @(negedge clk);
        reset             = rs;
        startOfFrame      = sof;
        shotValid         = sv;
        shotVelX          = 11'(sx);
        shotVelY          = 11'(sy);
        collisionOccurred = co;
        velXIn            = 11'(ix);
        velYIn            = 11'(iy);
        holeHit           = hh;
        respawn           = rp;
        model_step(rs, sof, sv, int'(shotVelX), int'(shotVelY), co,
                   int'(velXIn), int'(velYIn), hh, rp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("posX", int'(topLeftPosX), e.px);
                chk("posY", int'(topLeftPosY), e.py);
                chk("velX", int'(velX), e.vx);
                chk("velY", int'(velY), e.vy);
                chk("shotReady", int'(shotReady), int'(e.rdy));
                chk("moving", int'(moving), int'(e.mov));
                chk("sunk", int'(sunk), int'(e.snk));
            end
        end
    end

    initial begin
        int sx, sy, ix, iy;
        reset = 1'b1; startOfFrame = 0; shotValid = 0; collisionOccurred = 0;
        holeHit = 0; respawn = 0; shotVelX = 0; shotVelY = 0; velXIn = 0; velYIn = 0;

        // Reset and idle readback.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Shot then one frame.
        drive(0, 0, 1, 64, -128, 0, 0, 0, 0, 0);
        frame();
        idle(1);

        // Sustained collision with changing input: only the first cycle loads.
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, (i == 0) ? -64 : 99, 20, 0, 0);
        frame();
        drive(0, 0, 0, 0, 0, 1, 99, -7, 0, 0);
        idle(1);

        // Ignored shot while moving, then hole and collision together.
        drive(0, 0, 1, 300, 300, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 55, 55, 1, 0);
        frame();
        drive(0, 0, 1, 10, 10, 1, 5, 5, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Friction run-down to IDLE.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            frame();
            idle(2);
        end
        frame();
        idle(1);

        // Large shot (clamped only with the macro), frames, reset mid-motion.
        drive(0, 0, 1, 1000, -1000, 0, 0, 0, 0, 0);
        frame();
        frame();
        drive(0, 1, 0, 0, 0, 1, -1024, 1023, 0, 0);
        frame();
        drive(1, 1, 0, 0, 0, 1, 7, 7, 0, 0);
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                sx = int'($urandom_range(0, 2047)) - 1024;
                sy = int'($urandom_range(0, 2047)) - 1024;
            end else begin
                sx = int'($urandom_range(0, 80)) - 40;
                sy = int'($urandom_range(0, 80)) - 40;
            end
            ix = int'($urandom_range(0, 2047)) - 1024;
            iy = int'($urandom_range(0, 60)) - 30;
            drive($urandom_range(0, 499) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, sx, sy,
                  $urandom_range(0, 5) == 0, ix, iy,
                  $urandom_range(0, 149) == 0,
                  $urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-ball kinematics engine and the producer side of the collision path. It owns one ball's fixed-point position and velocity, launches the ball on a cue shot, and integrates motion once per video frame. It applies friction and accepts corrected velocities and hole events from `hit_controller`. Its position and velocity outputs feed `hit_controller` and the ball drawer; one instance is built per ball.

## Interface
- `INIT_X`, 280: reset/respawn top-left X, pixels
- `INIT_Y`, 220: reset/respawn top-left Y, pixels
- `FRAC_BITS`, 6: fractional bits of position; velocity unit is 1/2^FRAC_BITS pixel per frame
- `FRICTION_PERIOD`, 4: frames between friction steps, ≥1
- `FRICTION_STEP`, 1: magnitude removed per component per friction step
- `MAX_SPEED`, 512: saturation bound, used only with `BALL_SPEED_CLAMP_EN`

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `startOfFrame` in 1: one-cycle pulse per frame
- `shotValid` in 1: cue shot request
- `shotVelX`, `shotVelY` in 11 signed: shot velocity
- `shotReady` out 1: high in IDLE
- `collisionOccurred` in 1: corrected velocity valid, may stay high for many cycles
- `velXIn`, `velYIn` in 11 signed: corrected velocity
- `holeHit` in 1: ball entered a hole
- `respawn` in 1: return a sunk ball to its initial position
- `topLeftPosX`, `topLeftPosY` out 11 signed: integer pixel position
- `velX`, `velY` out 11 signed: current velocity
- `moving` out 1: high in MOVING
- `sunk` out 1: high in SUNK

## Operation
- States: IDLE, MOVING, SUNK.
- IDLE to MOVING: on `shotValid`. Velocity loads the shot values in the next cycle. The friction counter clears.
- `shotValid` outside IDLE is ignored.
- MOVING to IDLE: at the friction step where both velocity components become 0.
- MOVING to SUNK: on `holeHit`. Velocity is zeroed and position frozen.
- SUNK to IDLE: on `respawn`. Position is set to `INIT_X`/`INIT_Y` with zero fraction.
- Collision lock: the first cycle of `collisionOccurred` in MOVING loads `velXIn`/`velYIn` and sets the lock. Further assertions are ignored until the lock clears on `startOfFrame`.
- Integration on `startOfFrame` in MOVING: each position accumulator (signed, 11+`FRAC_BITS` bits) adds the sign-extended registered velocity. The velocity value used is the one held before this cycle's updates.
- Position output: accumulator arithmetically shifted right by `FRAC_BITS`, which floors toward negative.
- Friction counter: counts `startOfFrame` in MOVING. At `FRICTION_PERIOD`-1 it wraps, and each nonzero component moves toward 0 by `FRICTION_STEP`. A component whose magnitude is ≤ step goes to exactly 0; the sign never flips.
- Priority within one cycle: `reset` > `holeHit` > collision load > friction > shot.
- Collision and friction in the same cycle: the collision value is loaded unmodified.
- `collisionOccurred`/`holeHit` in IDLE or SUNK: ignored.

## Timing
- All state changes occur on the rising `clk` edge; outputs are registered.
- Reset values: position `INIT_X`/`INIT_Y` with zero fraction, velocity 0, state IDLE, `shotReady`=1, `moving`=0, `sunk`=0, lock clear, friction counter 0.
- Reset mid-motion returns to the reset values in one cycle, with no pending effects.
- Latency: shot → `moving` and `velX`/`velY` valid: 1 cycle.
- Latency: collision → new velocity: 1 cycle.
- Latency: `startOfFrame` → new position: 1 cycle.
- Latency: `holeHit` → `sunk`: 1 cycle.

## Configuration
- `BALL_SPEED_CLAMP_EN` defined: shot and collision velocities saturate per component to ±`MAX_SPEED` before loading.
- `BALL_SPEED_CLAMP_EN` undefined: shot and collision velocities load unmodified, so the full 11-bit range passes through.

## Structure
- `ball_pkg`: state enum `ball_state_t`, typedef `vel_t` (logic signed [10:0]), default `FRAC_BITS`, pixel-width constants. The package is shared with `hit_controller`.
- Sub-module `velocity_decay`: combinational toward-zero step of one component by `FRICTION_STEP`, instantiated twice.

## Test plan
- Reset, then read outputs: position (280,220), velocity 0, `shotReady`=1, `moving`=0.
- Shot (64,-128), then one `startOfFrame`: position (281,218) after 1 cycle, `moving`=1.
- `collisionOccurred` high for 5 cycles, with `velXIn` changing from -64 to 99 on cycle 2: `velX`=-64, 99 is ignored, and the lock clears after the next `startOfFrame`.
- `FRICTION_PERIOD`=1, shot (2,0), step 1: `velX` reads 1 then 0 over two frames, then state returns to IDLE with `shotReady`=1.
- `holeHit` and `collisionOccurred` in the same cycle: `sunk`=1, velocity 0. Then `respawn`: position (280,220), state IDLE.
- With `BALL_SPEED_CLAMP_EN`, shot (1000,-1000): velocity (512,-512). Without the macro, the same shot gives (1000,-1000).
